min_sort_ctrl: RTL and testbench

Sequential controller that feeds the combinational minimum-mask core and turns its bit-slice mask into a sorted output stream. It collects a batch of M words of N bits, one per cycle. It presents the batch to the core as an M×N vector, reads back slice 0 of the core's N×M h-matrix (the minimum-candidate mask), then emits words in ascending order, one per output handshake. Each emitted word is retired by overwriting it with all-ones before the next selection.

---
 rtl/min_sort_ctrl.sv | 153 +++++++++++++++
 tb/tb_min_sort_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/min_sort_ctrl.sv
// -----------------------------------------------------------------------------
// sort_pkg / min_sort_ctrl
//
// Purpose:
//   Controller for the combinational minimum-mask core. It collects a batch of
//   M words of N bits, one per accepted input. It presents the batch to the
//   core as o_chi and reads back slice 0 of the core's h-matrix, which is the
//   minimum-candidate mask. It then emits the words in ascending order, one
//   per output handshake. Each emitted word is retired by overwriting it with
//   all-ones, so it can never win a later selection.
//
// Ports:
//   i_clk       in   1      clock, single domain
//   i_rst_n     in   1      synchronous, active-low reset
//   i_data      in   N      input word
//   i_valid     in   1      i_data valid
//   o_ready     out  1      block accepts input this cycle (LOAD)
//   o_chi       out  M x N  batch vector to the core, word k at o_chi[k]
//   i_h_matrix  in   N x M  h-matrix from the core, only slice 0 is used
//   o_data      out  N      current minimum word
//   o_idx       out  IW     original load index of o_data (SORT_IDX_OUT_EN only)
//   o_valid     out  1      o_data valid (EMIT)
//   i_ready     in   1      downstream accepts o_data
//   o_last      out  1      o_data is the final word of the batch
//   o_busy      out  1      batch in progress
//
// Configuration macro:
//   SORT_IDX_OUT_EN  when defined, the o_idx port exists and carries the
//                    selected index. Sorting behaviour is identical either way.
// -----------------------------------------------------------------------------
package sort_pkg;
    localparam int M = 4;
    localparam int N = 8;
endpackage

module min_sort_ctrl
    import sort_pkg::*;
#(
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N-1:0]          i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [M-1:0][N-1:0]   o_chi,
    input  logic [N-1:0][M-1:0]   i_h_matrix,
    output logic [N-1:0]          o_data,
`ifdef SORT_IDX_OUT_EN
    output logic [IW-1:0]         o_idx,
`endif
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [IW:0] LAST_CNT = (IW+1)'(M - 1);

    state_t               state;
    logic [IW:0]          cnt;
    logic [M-1:0]         active;
    logic [M-1:0][N-1:0]  chi_reg;

    logic [M-1:0]         cand;
    logic [IW-1:0]        sel;
    logic                 emit;
    logic                 last_hit;

    // Lowest set bit wins, which makes equal values leave in load order.
    function automatic logic [IW-1:0] lowest_set(input logic [M-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (v[k]) r = IW'(k);
        end
        return r;
    endfunction

    // Only slice 0 of the h-matrix carries the minimum mask.
    generate
        if (N > 1) begin : g_hm_unused
            logic unused_hm;
            assign unused_hm = ^i_h_matrix[N-1:1];
        end
    endgenerate

    // ---- selection: core mask -> priority encoder -> output mux ----
    // Retired slots hold all-ones and are also masked off by active, so an
    // all-ones minimum still resolves to the lowest live index.
    assign emit     = (state == S_EMIT);
    assign cand     = i_h_matrix[0] & active;
    assign sel      = lowest_set(cand);
    assign last_hit = (cnt == LAST_CNT);

    assign o_chi    = chi_reg;
    assign o_ready  = (state == S_LOAD);
    assign o_valid  = emit;
    assign o_data   = emit ? chi_reg[sel] : '0;
    assign o_last   = emit & last_hit;
    assign o_busy   = emit | (cnt != '0);
`ifdef SORT_IDX_OUT_EN
    assign o_idx    = emit ? sel : '0;
`endif

    // ---- registered state: batch storage and control ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_LOAD;
            cnt     <= '0;
            active  <= '0;
            chi_reg <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (i_valid) begin
                        chi_reg[cnt[IW-1:0]] <= i_data;
                        active[cnt[IW-1:0]]  <= 1'b1;
                        if (last_hit) begin
                            state <= S_EMIT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_ready) begin
                        chi_reg[sel] <= '1;
                        active[sel]  <= 1'b0;
                        if (last_hit) begin
                            state  <= S_LOAD;
                            cnt    <= '0;
                            active <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_min_sort_ctrl
//
// Purpose:
//   Directed bench for min_sort_ctrl with M=4, N=8. A behavioural stand-in for
//   the minimum-mask core drives slice 0 of the h-matrix: bit k is set when
//   o_chi[k] equals the smallest word currently presented. Inputs are driven
//   and outputs sampled on the falling clock edge.
//   Honours SORT_IDX_OUT_EN for the optional o_idx port.
// -----------------------------------------------------------------------------
module tb_min_sort_ctrl;
    localparam int M  = sort_pkg::M;
    localparam int N  = sort_pkg::N;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [M-1:0][N-1:0]  o_chi;
    logic [N-1:0][M-1:0]  h_mat;
    logic [N-1:0]         o_data;
`ifdef SORT_IDX_OUT_EN
    logic [IW-1:0]        o_idx;
`endif
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;
    logic                 o_busy;

    int n_checks;
    int n_errors;

    min_sort_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_chi      (o_chi),
        .i_h_matrix (h_mat),
        .o_data     (o_data),
`ifdef SORT_IDX_OUT_EN
        .o_idx      (o_idx),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the minimum-mask core.
    always_comb begin
        logic [N-1:0] mn;
        mn    = '1;
        h_mat = '0;
        for (int k = 0; k < M; k++) begin
            if (o_chi[k] < mn) mn = o_chi[k];
        end
        for (int k = 0; k < M; k++) begin
            h_mat[0][k] = (o_chi[k] == mn);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] d, input logic busy);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        i_ready = 1'b0;
        check("ld_ready", o_ready, 1);
        check("ld_valid", o_valid, 0);
        check("ld_busy", o_busy, busy);
    endtask

    task automatic gap(input logic busy);
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 8'hAA;
        check("gap_ready", o_ready, 1);
        check("gap_busy", o_busy, busy);
    endtask

    // One output word; i_valid is held high with a zero word to show that
    // input is ignored while emitting.
    task automatic expect_out(input logic [N-1:0] d, input int idx, input logic last);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = '0;
        i_ready = 1'b1;
        check("out_valid", o_valid, 1);
        check("out_ready", o_ready, 0);
        check("out_busy", o_busy, 1);
        check("out_data", o_data, d);
        check("out_last", o_last, last);
        check("out_src", o_chi[idx], d);
`ifdef SORT_IDX_OUT_EN
        check("out_idx", o_idx, idx);
`endif
        @(posedge clk);
        #1;
        check("retired", o_chi[idx], {N{1'b1}});
    endtask

    task automatic check_idle();
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("idle_ready", o_ready, 1);
        check("idle_valid", o_valid, 0);
        check("idle_busy", o_busy, 0);
        check("idle_data", o_data, 0);
        check("idle_last", o_last, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_data", o_data, 0);
        check("rst_last", o_last, 0);
        check("rst_chi", o_chi, 0);
        rst_n = 1'b1;

        // Basic sort, back-to-back load and unloaded output.
        push(8'd5, 1'b0); push(8'd3, 1'b1); push(8'd9, 1'b1); push(8'd1, 1'b1);
        expect_out(8'd1, 3, 1'b0);
        expect_out(8'd3, 1, 1'b0);
        expect_out(8'd5, 0, 1'b0);
        expect_out(8'd9, 2, 1'b1);
        check_idle();

        // Ties leave in load order.
        push(8'd7, 1'b0); push(8'd2, 1'b1); push(8'd7, 1'b1); push(8'd2, 1'b1);
        expect_out(8'd2, 1, 1'b0);
        check("tie_keep3", o_chi[3], 8'd2);
        expect_out(8'd2, 3, 1'b0);
        expect_out(8'd7, 0, 1'b0);
        check("tie_keep2", o_chi[2], 8'd7);
        expect_out(8'd7, 2, 1'b1);
        check_idle();

        // Every word all-ones.
        push(8'hFF, 1'b0); push(8'hFF, 1'b1); push(8'hFF, 1'b1); push(8'hFF, 1'b1);
        expect_out(8'hFF, 0, 1'b0);
        expect_out(8'hFF, 1, 1'b0);
        expect_out(8'hFF, 2, 1'b0);
        expect_out(8'hFF, 3, 1'b1);
        check_idle();

        // Backpressure on the first output.
        push(8'd4, 1'b0); push(8'd0, 1'b1); push(8'd8, 1'b1); push(8'd6, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = '0;
            i_ready = 1'b0;
            check("bp_valid", o_valid, 1);
            check("bp_data", o_data, 8'd0);
            check("bp_last", o_last, 0);
            check("bp_src", o_chi[1], 8'd0);
            check("bp_chi0", o_chi[0], 8'd4);
`ifdef SORT_IDX_OUT_EN
            check("bp_idx", o_idx, 1);
`endif
        end
        expect_out(8'd0, 1, 1'b0);
        expect_out(8'd4, 0, 1'b0);
        expect_out(8'd6, 3, 1'b0);
        expect_out(8'd8, 2, 1'b1);
        check_idle();

        // Input gaps: i_valid 1,0,0,1,1,0,1.
        push(8'd10, 1'b0); gap(1'b1); gap(1'b1);
        push(8'd20, 1'b1); push(8'd30, 1'b1); gap(1'b1);
        push(8'd40, 1'b1);
        expect_out(8'd10, 0, 1'b0);
        expect_out(8'd20, 1, 1'b0);
        expect_out(8'd30, 2, 1'b0);
        expect_out(8'd40, 3, 1'b1);
        check_idle();

        // Reset part-way through emitting.
        push(8'd8, 1'b0); push(8'd6, 1'b1); push(8'd4, 1'b1); push(8'd2, 1'b1);
        expect_out(8'd2, 3, 1'b0);
        expect_out(8'd4, 2, 1'b0);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_valid", o_valid, 0);
        check("mr_ready", o_ready, 1);
        check("mr_busy", o_busy, 0);
        check("mr_data", o_data, 0);
        check("mr_chi", o_chi, 0);
        push(8'd3, 1'b0); push(8'd2, 1'b1); push(8'd1, 1'b1); push(8'd0, 1'b1);
        expect_out(8'd0, 3, 1'b0);
        expect_out(8'd1, 2, 1'b0);
        expect_out(8'd2, 1, 1'b0);
        expect_out(8'd3, 0, 1'b1);
        check_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
